// File: rtl/std_mem_d1_arbiter_pkg.sv
// Shared types and helpers for the std_mem_d1 round-robin arbiter.
package std_mem_arb_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Largest requester count the picker and index widths are sized for.
  localparam int MAX_REQ = 16;

  // Width of a requester index (ptr, owner); never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/std_mem_d1_arbiter_if.sv
// Requester-side and memory-side signal bundle for std_mem_d1_arbiter.
interface std_mem_d1_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 4
);
  // Requester go/done handshake, packed per requester.
  logic [NUM_REQ-1:0]          req_go;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*IDX_SIZE-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]    req_write_data;
  logic [NUM_REQ-1:0]          req_done;
  logic [WIDTH-1:0]            req_read_data;

  // Single std_mem_d1 port.
  logic [IDX_SIZE-1:0]         mem_addr0;
  logic [WIDTH-1:0]            mem_write_data;
  logic                        mem_write_en;
  logic [WIDTH-1:0]            mem_read_data;
  logic                        mem_done;

  // Arbiter view.
  modport slave (
    input  req_go, req_write, req_addr, req_write_data, mem_read_data, mem_done,
    output req_done, req_read_data, mem_addr0, mem_write_data, mem_write_en
  );

  // Requesters plus memory view.
  modport master (
    output req_go, req_write, req_addr, req_write_data, mem_read_data, mem_done,
    input  req_done, req_read_data, mem_addr0, mem_write_data, mem_write_en
  );
endinterface

// File: rtl/std_mem_d1_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module std_rr_pick
  import std_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IW:0] cand;

  // Scan NUM_REQ rotated positions starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!valid && req[cand[IW-1:0]]) begin
        valid                 = 1'b1;
        idx                   = cand[IW-1:0];
        grant[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin arbiter sharing one std_mem_d1 port among NUM_REQ go/done requesters.
module std_mem_d1_arbiter
  import std_mem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4,
  parameter int NUM_REQ  = 4
) (
  input logic                 clk,
  input logic                 reset,
  std_mem_d1_arbiter_if.slave bus
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_e          state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       owner;
  logic                lat_write;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [IW-1:0]       ptr_next;
  logic [NUM_REQ-1:0]  owner_onehot;

  logic                win_write;
  logic [IDX_SIZE-1:0] win_addr;
  logic [WIDTH-1:0]    win_wdata;

  std_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_go),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Pointer moves just past the winner; explicit wrap keeps non-power-of-two counts legal.
  assign ptr_next     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  // Select the winner's slice of the packed request buses using the one-hot grant.
  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        win_write = bus.req_write[i];
        win_addr  = bus.req_addr[i*IDX_SIZE +: IDX_SIZE];
        win_wdata = bus.req_write_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbiter FSM: grant in IDLE, drive the port in ISSUE, wait for write done, pulse done in RESP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state              <= IDLE;
      ptr                <= '0;
      owner              <= '0;
      lat_write          <= 1'b0;
      bus.req_done       <= '0;
      bus.req_read_data  <= '0;
      bus.mem_addr0      <= '0;
      bus.mem_write_data <= '0;
      bus.mem_write_en   <= 1'b0;
    end else begin
      // Done and write enable are single-cycle pulses.
      bus.req_done     <= '0;
      bus.mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner              <= pick_idx;
            lat_write          <= win_write;
            bus.mem_addr0      <= win_addr;
            bus.mem_write_data <= win_wdata;
            bus.mem_write_en   <= win_write;
            ptr                <= ptr_next;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_write) begin
            state <= WAIT;
          end else begin
            bus.req_read_data <= bus.mem_read_data;
            bus.req_done      <= owner_onehot;
            state             <= RESP;
          end
        end
        WAIT: begin
          if (bus.mem_done) begin
            bus.req_done <= owner_onehot;
            state        <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
